// File: rtl/sm_0535_uart_pkg.sv
// Shared definitions for the UART message controllers: ASCII framing bytes,
// the default path count and the controller state encoding.
package sm_0535_uart_pkg;

   localparam int NUM_PATHS_DEF = 17;

   localparam logic [7:0] ASCII_SOF  = 8'h2D;
   localparam logic [7:0] ASCII_SEP  = 8'h2D;
   localparam logic [7:0] ASCII_EOF  = 8'h23;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_SOF,
      ST_SCAN,
      ST_SEND_TENS,
      ST_SEND_ONES,
      ST_SEND_SEP,
      ST_SEND_EOF,
      ST_WAIT_TX,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sm_0535_path_to_ascii.sv
// Converts a path index (0..99) into two zero-padded ASCII decimal digits.
module sm_0535_path_to_ascii
   import sm_0535_uart_pkg::*;
#(
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [7:0]       o_tens,
   output logic [7:0]       o_ones
);

   logic [6:0] w_val;

   // Indices never exceed 99, so a 7-bit working value holds every case.
   always_comb begin
      w_val  = 7'(i_idx);
      o_tens = ASCII_ZERO + {1'b0, w_val / 7'd10};
      o_ones = ASCII_ZERO + {1'b0, w_val % 7'd10};
   end

endmodule

// File: rtl/sm_0535_uart_tx_controller.sv
// Snapshots the path-availability vector and sends the unavailable indices
// as an ASCII frame "-NN-NN-#", one byte per tx_dv/tx_done handshake.
module sm_0535_uart_tx_controller
   import sm_0535_uart_pkg::*;
#(
   parameter int NUM_PATHS = NUM_PATHS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_send_req,
   input  logic [NUM_PATHS-1:0] i_paths_av,
   input  logic                 i_tx_done,
   output logic                 o_tx_dv,
   output logic [7:0]           o_tx_byte,
   output logic                 o_busy,
   output logic                 o_msg_done
);

   localparam int IDX_W = $clog2(NUM_PATHS + 1);

   state_t               r_state;
   state_t               r_ret;
   logic [NUM_PATHS-1:0] r_mask;
   logic [IDX_W-1:0]     r_idx;
   logic [7:0]           r_tx_byte;

   state_t               w_next;
   state_t               w_ret_next;
   logic                 w_capture;
   logic                 w_idx_inc;
   logic                 w_is_send;
   logic [7:0]           w_byte;
   logic [7:0]           w_tens;
   logic [7:0]           w_ones;

   sm_0535_path_to_ascii #(
      .IDX_W (IDX_W)
   ) u_path_to_ascii (
      .i_idx  (r_idx),
      .o_tens (w_tens),
      .o_ones (w_ones)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ret     <= ST_IDLE;
         r_mask    <= '1;
         r_idx     <= '0;
         r_tx_byte <= '0;
      end else begin
         r_state <= w_next;
         r_ret   <= w_ret_next;
         if (w_is_send) begin
            r_tx_byte <= w_byte;
         end
         if (w_capture) begin
            r_mask <= i_paths_av;
            r_idx  <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Every SEND state strobes one byte and parks in WAIT_TX until the byte
   // transmitter finishes; the byte register keeps tx_byte stable meanwhile.
   always_comb begin
      w_next     = r_state;
      w_ret_next = r_ret;
      w_capture  = 1'b0;
      w_idx_inc  = 1'b0;
      w_is_send  = 1'b0;
      w_byte     = r_tx_byte;
      o_busy     = 1'b1;
      o_msg_done = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_send_req) begin
               w_capture = 1'b1;
               w_next    = ST_SEND_SOF;
            end
         end
         ST_SEND_SOF: begin
            w_is_send  = 1'b1;
            w_byte     = ASCII_SOF;
            w_ret_next = ST_SCAN;
            w_next     = ST_WAIT_TX;
         end
         ST_SCAN: begin
            if (r_idx == IDX_W'(NUM_PATHS)) begin
               w_next = ST_SEND_EOF;
            end else if (!r_mask[r_idx]) begin
               w_next = ST_SEND_TENS;
            end else begin
               w_idx_inc = 1'b1;
            end
         end
         ST_SEND_TENS: begin
            w_is_send  = 1'b1;
            w_byte     = w_tens;
            w_ret_next = ST_SEND_ONES;
            w_next     = ST_WAIT_TX;
         end
         ST_SEND_ONES: begin
            w_is_send  = 1'b1;
            w_byte     = w_ones;
            w_ret_next = ST_SEND_SEP;
            w_next     = ST_WAIT_TX;
         end
         ST_SEND_SEP: begin
            w_is_send  = 1'b1;
            w_byte     = ASCII_SEP;
            w_idx_inc  = 1'b1;
            w_ret_next = ST_SCAN;
            w_next     = ST_WAIT_TX;
         end
         ST_SEND_EOF: begin
            w_is_send  = 1'b1;
            w_byte     = ASCII_EOF;
            w_ret_next = ST_DONE;
            w_next     = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done) begin
               w_next = r_ret;
            end
         end
         ST_DONE: begin
            o_busy     = 1'b0;
            o_msg_done = 1'b1;
            w_next     = ST_IDLE;
            // A fresh request is already honoured in the completion cycle.
            if (i_send_req) begin
               w_capture = 1'b1;
               w_next    = ST_SEND_SOF;
            end
         end
         default: begin
            o_busy = 1'b0;
            w_next = ST_IDLE;
         end
      endcase

      o_tx_dv   = w_is_send;
      o_tx_byte = w_byte;
   end

endmodule

// File: tb/tb_sm_0535_uart_tx_controller.sv
// Self-checking bench: a byte-transmitter responder collects every strobed byte
// and each scenario compares the collected frame with a frame built from the mask.
module tb_sm_0535_uart_tx_controller;

   localparam int NP = 17;

   logic          clk;
   logic          rst_n;
   logic          send_req;
   logic [NP-1:0] paths_av;
   logic          tx_done;
   logic          o_tx_dv;
   logic [7:0]    o_tx_byte;
   logic          o_busy;
   logic          o_msg_done;

   logic          respDone;
   logic          spurDone;
   assign tx_done = respDone | spurDone;

   logic [7:0] rxq[$];
   logic [7:0] expQ[$];
   logic [7:0] lastByte;
   int         protoErr;
   int         stableErr;
   int         msgDoneCnt;
   int         txDvCnt;
   int         txDelay;
   bit         randDelay;
   bit         outstanding;
   int         cnt;
   int         compared;
   int         mismatched;

   sm_0535_uart_tx_controller #(
      .NUM_PATHS (NP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_send_req (send_req),
      .i_paths_av (paths_av),
      .i_tx_done  (tx_done),
      .o_tx_dv    (o_tx_dv),
      .o_tx_byte  (o_tx_byte),
      .o_busy     (o_busy),
      .o_msg_done (o_msg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference frame: "-", then "TU-" for every cleared index, then "#".
   function automatic void buildExpected(input logic [NP-1:0] m);
      expQ.delete();
      expQ.push_back(8'h2D);
      for (int i = 0; i < NP; i++) begin
         if (!m[i]) begin
            expQ.push_back(8'(48 + i / 10));
            expQ.push_back(8'(48 + i % 10));
            expQ.push_back(8'h2D);
         end
      end
      expQ.push_back(8'h23);
   endfunction

   function automatic int frameDiff();
      int n;
      n = (rxq.size() < expQ.size()) ? rxq.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         if (rxq[i] !== expQ[i]) return i;
      end
      if (rxq.size() != expQ.size()) return n;
      return -1;
   endfunction

   function automatic logic [7:0] gotAt(input int i);
      return (i < rxq.size()) ? rxq[i] : 8'hxx;
   endfunction

   function automatic logic [7:0] expAt(input int i);
      return (i < expQ.size()) ? expQ[i] : 8'hxx;
   endfunction

   // Byte-transmitter model: records bytes, answers each tx_dv with tx_done.
   initial begin
      respDone    = 1'b0;
      outstanding = 1'b0;
      cnt         = 0;
      forever begin
         @(negedge clk);
         respDone = 1'b0;
         if (!rst_n) begin
            outstanding = 1'b0;
         end else begin
            if (outstanding) begin
               if (o_tx_byte !== lastByte) stableErr++;
               if (cnt == 0) begin
                  respDone    = 1'b1;
                  outstanding = 1'b0;
               end else begin
                  cnt--;
               end
            end
            if (o_tx_dv === 1'b1) begin
               txDvCnt++;
               if (outstanding) protoErr++;
               rxq.push_back(o_tx_byte);
               lastByte    = o_tx_byte;
               outstanding = 1'b1;
               cnt         = randDelay ? int'($urandom_range(0, 6)) : txDelay;
            end
            if (o_msg_done === 1'b1) msgDoneCnt++;
         end
      end
   end

   task automatic startFrame(input logic [NP-1:0] m);
      @(negedge clk);
      rxq.delete();
      send_req = 1'b1;
      paths_av = m;
      @(negedge clk);
      send_req = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit ok, output logic busyAt);
      ok     = 1'b0;
      busyAt = 1'bx;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (o_msg_done === 1'b1) begin
            ok     = 1'b1;
            busyAt = o_busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int dv0;
      rst_n = 1'b0;
      @(negedge clk);
      compared++;
      if (o_tx_dv !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset tx_dv: got %b need 0", o_tx_dv);
      end
      compared++;
      if (o_tx_byte !== 8'h00) begin
         mismatched++; $display("[TB] FAIL reset tx_byte: got %02h need 00", o_tx_byte);
      end
      compared++;
      if (o_busy !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset busy: got %b need 0", o_busy);
      end
      compared++;
      if (o_msg_done !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset msg_done: got %b need 0", o_msg_done);
      end
      #1 rst_n = 1'b1;
      dv0 = txDvCnt;
      repeat (100) @(negedge clk);
      compared++;
      if (txDvCnt != dv0 || o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle quiet: got %0d tx_dv busy=%b need 0 tx_dv busy=0", txDvCnt - dv0, o_busy);
      end
   endtask

   task automatic test_frame(input string name, input logic [NP-1:0] m);
      int   md0;
      int   pe0;
      int   se0;
      int   d;
      bit   ok;
      logic busyAt;
      md0 = msgDoneCnt;
      pe0 = protoErr;
      se0 = stableErr;
      buildExpected(m);
      startFrame(m);
      compared++;
      if (o_busy !== 1'b1 || o_tx_dv !== 1'b1 || o_tx_byte !== 8'h2D) begin
         mismatched++;
         $display("[TB] FAIL %s start: got busy=%b dv=%b byte=%02h need 1 1 2d", name, o_busy, o_tx_dv, o_tx_byte);
      end
      waitDone(3000, ok, busyAt);
      compared++;
      if (!ok) begin
         mismatched++; $display("[TB] FAIL %s timeout: got no msg_done need msg_done", name);
      end
      compared++;
      if (busyAt !== 1'b0) begin
         mismatched++; $display("[TB] FAIL %s busy at msg_done: got %b need 0", name, busyAt);
      end
      @(negedge clk);
      d = frameDiff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("[TB] FAIL %s frame: byte %0d got %02h need %02h (got %0d bytes need %0d)",
                  name, d, gotAt(d), expAt(d), rxq.size(), expQ.size());
      end
      compared++;
      if (msgDoneCnt - md0 != 1) begin
         mismatched++; $display("[TB] FAIL %s msg_done count: got %0d need 1", name, msgDoneCnt - md0);
      end
      compared++;
      if (protoErr != pe0 || stableErr != se0) begin
         mismatched++;
         $display("[TB] FAIL %s handshake: got %0d overlaps %0d byte changes need 0 0",
                  name, protoErr - pe0, stableErr - se0);
      end
   endtask

   task automatic test_random();
      randDelay = 1'b1;
      for (int k = 0; k < 6; k++) begin
         test_frame($sformatf("random%0d", k), NP'($urandom));
      end
      randDelay = 1'b0;
   endtask

   task automatic test_busy_ignore();
      logic [NP-1:0] m1;
      int   md0;
      int   dv0;
      int   d;
      bit   ok;
      logic busyAt;
      m1  = NP'($urandom) & 17'h1F7FE;
      md0 = msgDoneCnt;
      randDelay = 1'b1;
      buildExpected(m1);
      startFrame(m1);
      repeat (4) @(negedge clk);
      send_req = 1'b1;
      paths_av = ~m1;
      @(negedge clk);
      send_req = 1'b0;
      paths_av = NP'($urandom);
      waitDone(3000, ok, busyAt);
      @(negedge clk);
      d = frameDiff();
      compared++;
      if (!ok || d != -1) begin
         mismatched++;
         $display("[TB] FAIL busy_ignore frame: byte %0d got %02h need %02h (done=%b)", d, gotAt(d), expAt(d), ok);
      end
      dv0 = txDvCnt;
      repeat (30) @(negedge clk);
      compared++;
      if (txDvCnt != dv0 || msgDoneCnt - md0 != 1 || o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL busy_ignore queued: got %0d extra tx_dv %0d msg_done busy=%b need 0 1 0",
                  txDvCnt - dv0, msgDoneCnt - md0, o_busy);
      end
      randDelay = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit reached;
      txDelay = 2;
      startFrame(17'h1EFF7);
      reached = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (rxq.size() >= 3) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      compared++;
      if (!reached) begin
         mismatched++; $display("[TB] FAIL reset_mid third byte: got %0d bytes need 3", rxq.size());
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      compared++;
      if (o_tx_dv !== 1'b0 || o_busy !== 1'b0 || o_msg_done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid outputs: got dv=%b busy=%b done=%b need 0 0 0", o_tx_dv, o_busy, o_msg_done);
      end
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      compared++;
      if (rxq.size() != 3 || o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid abandoned: got %0d bytes busy=%b need 3 bytes busy=0", rxq.size(), o_busy);
      end
      test_frame("after_reset", 17'h0F0F0);
   endtask

   task automatic test_spurious_done();
      int dv0;
      int d;
      bit ok;
      logic busyAt;
      dv0 = txDvCnt;
      @(negedge clk);
      spurDone = 1'b1;
      @(negedge clk);
      spurDone = 1'b0;
      repeat (5) @(negedge clk);
      compared++;
      if (txDvCnt != dv0 || o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL spurious idle: got %0d tx_dv busy=%b need 0 busy=0", txDvCnt - dv0, o_busy);
      end
      txDelay = 0;
      buildExpected('1);
      startFrame('1);
      repeat (3) @(negedge clk);
      spurDone = 1'b1;
      repeat (5) @(negedge clk);
      spurDone = 1'b0;
      waitDone(500, ok, busyAt);
      @(negedge clk);
      d = frameDiff();
      compared++;
      if (!ok || d != -1) begin
         mismatched++;
         $display("[TB] FAIL spurious scan frame: byte %0d got %02h need %02h (done=%b)", d, gotAt(d), expAt(d), ok);
      end
   endtask

   task automatic test_back_to_back();
      logic [NP-1:0] m1;
      logic [NP-1:0] m2;
      bit   seen;
      bit   ok;
      logic busyAt;
      int   d;
      m1 = NP'($urandom);
      m2 = NP'($urandom);
      txDelay = 1;
      buildExpected(m1);
      startFrame(m1);
      seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (o_msg_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      d = frameDiff();
      compared++;
      if (!seen || d != -1) begin
         mismatched++;
         $display("[TB] FAIL back_to_back first: byte %0d got %02h need %02h (done=%b)", d, gotAt(d), expAt(d), seen);
      end
      rxq.delete();
      buildExpected(m2);
      send_req = 1'b1;
      paths_av = m2;
      @(negedge clk);
      send_req = 1'b0;
      compared++;
      if (o_busy !== 1'b1 || o_tx_dv !== 1'b1 || o_tx_byte !== 8'h2D) begin
         mismatched++;
         $display("[TB] FAIL back_to_back accept: got busy=%b dv=%b byte=%02h need 1 1 2d", o_busy, o_tx_dv, o_tx_byte);
      end
      waitDone(3000, ok, busyAt);
      @(negedge clk);
      d = frameDiff();
      compared++;
      if (!ok || d != -1) begin
         mismatched++;
         $display("[TB] FAIL back_to_back second: byte %0d got %02h need %02h (done=%b)", d, gotAt(d), expAt(d), ok);
      end
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: got no completion need completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      protoErr   = 0;
      stableErr  = 0;
      msgDoneCnt = 0;
      txDvCnt    = 0;
      txDelay    = 4;
      randDelay  = 1'b0;
      lastByte   = 8'h00;
      send_req   = 1'b0;
      paths_av   = '1;
      spurDone   = 1'b0;
      rst_n      = 1'b0;

      test_reset();
      txDelay = 4;
      test_frame("example", 17'h1EFF7);
      txDelay = 0;
      test_frame("all_ones", '1);
      txDelay = 3;
      test_frame("all_zeros", '0);
      test_random();
      test_busy_ignore();
      test_reset_mid();
      test_spurious_done();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
